// File: rtl/systolic_output_checker_if.sv
// rtl/systolic_output_checker_if.sv - control, compare-bus and fault-report bundle of the systolic output checker
interface systolic_output_checker_if #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 8
);
  localparam int FC_W  = $clog2(ROWS * COLS + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  logic                      start;
  logic [CNT_W-1:0]          wait_cycles;
  logic                      clear_map;
  logic [COLS*WORD_SIZE-1:0] dut_bottom_out_bus;
  logic [COLS*WORD_SIZE-1:0] ref_bottom_out_bus;
  logic                      busy;
  logic                      done;
  logic [ROWS*COLS-1:0]      err_map;
  logic                      fault_any;
  logic [FC_W-1:0]           fault_count;
  logic                      first_fault_valid;
  logic [ROW_W-1:0]          first_fault_row;
  logic [COL_W-1:0]          first_fault_col;

  modport master (
    output start, wait_cycles, clear_map, dut_bottom_out_bus, ref_bottom_out_bus,
    input  busy, done, err_map, fault_any, fault_count,
           first_fault_valid, first_fault_row, first_fault_col
  );

  modport slave (
    input  start, wait_cycles, clear_map, dut_bottom_out_bus, ref_bottom_out_bus,
    output busy, done, err_map, fault_any, fault_count,
           first_fault_valid, first_fault_row, first_fault_col
  );
endinterface

// File: rtl/systolic_output_checker.sv
// rtl/systolic_output_checker.sv - windowed DUT-vs-golden bottom_out comparator with sticky per-PE error map
module systolic_output_checker #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = 8
) (
  input logic                    clk,
  input logic                    rst,
  systolic_output_checker_if.slave bus
);
  localparam int FC_W  = $clog2(ROWS * COLS + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [ROW_W-1:0] sample_idx;

  // One sample of lane mismatches is staged here and merged into the map on the following edge.
  logic             pend_valid;
  logic [ROW_W-1:0] pend_row;
  logic [COLS-1:0]  pend_mism;

  logic [COLS-1:0]      mism_now;
  logic [COLS-1:0]      row_bits;
  logic [COLS-1:0]      new_bits;
  logic [ROWS*COLS-1:0] new_mask;
  logic [FC_W-1:0]      new_cnt;
  logic [COL_W-1:0]     first_col;

  always_comb begin
    mism_now = '0;
    for (int c = 0; c < COLS; c++) begin
      mism_now[c] = bus.dut_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE] !=
                    bus.ref_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Only bits not already set in the staged row count toward fault_count.
  always_comb begin
    row_bits = '0;
    new_mask = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (pend_row == ROW_W'(r)) begin
        row_bits = bus.err_map[r*COLS +: COLS];
      end
    end
    new_bits = pend_mism & ~row_bits;
    for (int r = 0; r < ROWS; r++) begin
      if (pend_row == ROW_W'(r)) begin
        new_mask[r*COLS +: COLS] = new_bits;
      end
    end
    new_cnt = '0;
    for (int c = 0; c < COLS; c++) begin
      new_cnt = new_cnt + FC_W'(new_bits[c]);
    end
    first_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (new_bits[c]) begin
        first_col = COL_W'(c);
      end
    end
  end

  assign bus.fault_any = |bus.err_map;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      sample_idx            <= '0;
      pend_valid            <= 1'b0;
      pend_row              <= '0;
      pend_mism             <= '0;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.err_map           <= '0;
      bus.fault_count       <= '0;
      bus.first_fault_valid <= 1'b0;
      bus.first_fault_row   <= '0;
      bus.first_fault_col   <= '0;
    end else begin
      bus.done   <= 1'b0;
      pend_valid <= 1'b0;

      if (pend_valid) begin
        bus.err_map     <= bus.err_map | new_mask;
        bus.fault_count <= bus.fault_count + new_cnt;
        if (!bus.first_fault_valid && (|new_bits)) begin
          bus.first_fault_valid <= 1'b1;
          bus.first_fault_row   <= pend_row;
          bus.first_fault_col   <= first_col;
        end
      end

      case (state)
        IDLE: begin
          if (bus.clear_map) begin
            bus.err_map           <= '0;
            bus.fault_count       <= '0;
            bus.first_fault_valid <= 1'b0;
            bus.first_fault_row   <= '0;
            bus.first_fault_col   <= '0;
          end
          if (bus.start) begin
            wait_cnt   <= bus.wait_cycles;
            sample_idx <= '0;
            bus.busy   <= 1'b1;
            state      <= (bus.wait_cycles != '0) ? WAIT : SAMPLE;
          end
        end
        WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            state <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        SAMPLE: begin
          pend_valid <= 1'b1;
          pend_row   <= sample_idx;
          pend_mism  <= mism_now;
          if (sample_idx == ROW_W'(ROWS - 1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            sample_idx <= sample_idx + ROW_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_output_checker.sv
// tb/tb_systolic_output_checker.sv - randomized bench for systolic_output_checker against a timeline model
module tb_systolic_output_checker;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int WORD_SIZE = 16;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_output_checker_if #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) bus ();

  systolic_output_checker #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: a window accepted at edge t0 with latency w0 samples at edges t0+w0+1..t0+w0+ROWS.
  bit [ROWS*COLS-1:0] m_map;
  int                 m_cnt;
  bit                 m_ffv;
  int                 m_ffr, m_ffc;
  bit                 m_busy, m_done;
  bit                 act, pv;
  int                 t0, w0, cyc, pk, rel;
  bit [COLS-1:0]      pm;

  initial begin
    m_map = '0; m_cnt = 0; m_ffv = 0; m_ffr = 0; m_ffc = 0;
    m_busy = 0; m_done = 0; act = 0; pv = 0; t0 = 0; w0 = 0; cyc = 0; pk = 0; pm = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_map = '0; m_cnt = 0; m_ffv = 0; m_ffr = 0; m_ffc = 0;
        act = 0; pv = 0; m_busy = 0; m_done = 0;
      end else begin
        if (pv) begin
          for (int c = 0; c < COLS; c++) begin
            if (pm[c] && !m_map[pk*COLS + c]) begin
              m_map[pk*COLS + c] = 1'b1;
              m_cnt++;
              if (!m_ffv) begin
                m_ffv = 1; m_ffr = pk; m_ffc = c;
              end
            end
          end
          pv = 0;
        end
        if (act && (cyc - t0 == w0 + ROWS + 1)) begin
          act = 0;
        end else if (!act) begin
          if (bus.clear_map) begin
            m_map = '0; m_cnt = 0; m_ffv = 0; m_ffr = 0; m_ffc = 0;
          end
          if (bus.start) begin
            act = 1; t0 = cyc; w0 = int'(bus.wait_cycles);
          end
        end
        m_busy = 0;
        m_done = 0;
        if (act) begin
          rel = cyc - t0;
          if (rel >= w0 + 1 && rel <= w0 + ROWS) begin
            pv = 1;
            pk = rel - w0 - 1;
            for (int c = 0; c < COLS; c++) begin
              pm[c] = bus.dut_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE] !=
                      bus.ref_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE];
            end
          end
          m_busy = (rel <= w0 + ROWS - 1);
          m_done = (rel == w0 + ROWS);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("err_map", bus.err_map, m_map);
        chk("fault_any", bus.fault_any, (m_map != 0));
        chk("fault_count", bus.fault_count, m_cnt);
        chk("first_fault_valid", bus.first_fault_valid, m_ffv);
        chk("first_fault_row", bus.first_fault_row, m_ffr);
        chk("first_fault_col", bus.first_fault_col, m_ffc);
      end
    end
  end

  task automatic drive_buses(input logic [COLS-1:0] mask);
    logic [WORD_SIZE-1:0] v, x;
    for (int c = 0; c < COLS; c++) begin
      v = WORD_SIZE'($urandom);
      x = WORD_SIZE'($urandom_range(1, (1 << WORD_SIZE) - 1));
      bus.dut_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE] = v;
      bus.ref_bottom_out_bus[c*WORD_SIZE +: WORD_SIZE] = mask[c] ? (v ^ x) : v;
    end
  endtask

  task automatic quiet();
    bus.start = 1'b0;
    bus.clear_map = 1'b0;
    drive_buses('0);
  endtask

  // Noise toggles start/clear/wait_cycles mid-window and corrupts lanes outside sample cycles.
  task automatic run_window(input int w, input logic [ROWS*COLS-1:0] mask, input bit noise,
                            input bit clr, output int dj);
    int k;
    dj = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.wait_cycles = CNT_W'(w);
    bus.clear_map = clr;
    drive_buses('0);
    for (int j = 0; j <= w + ROWS; j++) begin
      @(negedge clk);
      if (bus.done && dj < 0) dj = j;
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.clear_map = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.wait_cycles = CNT_W'($urandom);
      k = j - w;
      if (k >= 0 && k < ROWS) drive_buses(mask[k*COLS +: COLS]);
      else drive_buses(noise ? COLS'($urandom) : '0);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear_map = 1'b1;
    @(negedge clk);
    bus.clear_map = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int dj;
    int wr;
    logic [ROWS*COLS-1:0] mr;
    bus.wait_cycles = '0;
    quiet();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_err_map", bus.err_map, 0);
    chk("reset_first_valid", bus.first_fault_valid, 0);
    rst = 1'b0;

    run_window(3, '0, 1'b0, 1'b0, dj);
    chk("t1_done_cycle", dj, 7);
    chk("t1_err_map", bus.err_map, 0);
    chk("t1_count", bus.fault_count, 0);

    run_window(2, 16'h0002, 1'b0, 1'b0, dj);
    chk("t2_err_map", bus.err_map, 16'h0002);
    chk("t2_first_row", bus.first_fault_row, 0);
    chk("t2_first_col", bus.first_fault_col, 1);
    chk("t2_count", bus.fault_count, 1);
    do_clear();

    run_window(1, 16'h4900, 1'b0, 1'b0, dj);
    chk("t3_err_map", bus.err_map, 16'h4900);
    chk("t3_count", bus.fault_count, 3);
    chk("t3_first_row", bus.first_fault_row, 2);
    chk("t3_first_col", bus.first_fault_col, 0);
    do_clear();

    run_window(2, 16'h0040, 1'b0, 1'b0, dj);
    run_window(1, 16'h1040, 1'b0, 1'b0, dj);
    chk("t4_err_map", bus.err_map, 16'h1040);
    chk("t4_count", bus.fault_count, 2);
    chk("t4_first_row", bus.first_fault_row, 1);
    chk("t4_first_col", bus.first_fault_col, 2);
    do_clear();
    chk("t4_clear_map", bus.err_map, 0);
    chk("t4_clear_valid", bus.first_fault_valid, 0);

    run_window(0, 16'h0000, 1'b1, 1'b0, dj);
    chk("t5_done_cycle", dj, 4);

    do_clear();
    @(negedge clk);
    bus.start = 1'b1;
    bus.wait_cycles = CNT_W'(1);
    drive_buses('0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    drive_buses(4'b1000);
    @(negedge clk);
    drive_buses('0);
    @(negedge clk);
    chk("t6_pre_rst_map", bus.err_map, 16'h0008);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_map", bus.err_map, 0);
    repeat (6) @(negedge clk);
    run_window(2, 16'h0100, 1'b0, 1'b0, dj);
    chk("t6_restart_map", bus.err_map, 16'h0100);

    for (int i = 0; i < 24; i++) begin
      wr = $urandom_range(0, 5);
      mr = (ROWS*COLS)'($urandom & $urandom & $urandom);
      run_window(wr, mr, 1'b1, 1'($urandom_range(0, 3) == 0), dj);
      chk("rand_done_cycle", dj, wr + ROWS);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
